// File: rtl/alu_ctrl_decode_pkg.sv
// Shared types for the ALU control decoder: aluctrl_t, operand selects and opcode/funct codes.
// The MOVZ/MOVN codes are only decoded when ALU_DECODE_MOVCOND_EN is defined.
package alu_ctrl_decode_pkg;

    typedef struct packed {
        logic f_add;
        logic f_sl;
        logic f_sr;
        logic f_and;
        logic f_or;
        logic f_xor;
        logic f_slt;
        logic f_sltu;
        logic f_mova;
        logic alt;
    } aluctrl_t;

    typedef enum logic [1:0] {
        ASEL_RS    = 2'd0,
        ASEL_SHAMT = 2'd1,
        ASEL_ZERO  = 2'd2
    } asel_t;

    typedef enum logic [1:0] {
        BSEL_RT       = 2'd0,
        BSEL_IMM_SEXT = 2'd1,
        BSEL_IMM_ZEXT = 2'd2,
        BSEL_IMM_LUI  = 2'd3
    } bsel_t;

    typedef enum logic [3:0] {
        AF_NONE,
        AF_ADD,
        AF_SL,
        AF_SR,
        AF_AND,
        AF_OR,
        AF_XOR,
        AF_SLT,
        AF_SLTU,
        AF_MOVA
    } alu_fn_e;

    typedef struct packed {
        aluctrl_t aluctrl;
        asel_t    asel;
        bsel_t    bsel;
        logic     ovchk;
        logic     alu;
        logic     ri;
    } dec_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_MOVZ = 6'h0A;
    localparam logic [5:0] FN_MOVN = 6'h0B;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Builds a complete ALU-class decode word; exactly one f_* bit is set.
    function automatic dec_t alu_op(alu_fn_e fn, logic alt, asel_t asel, bsel_t bsel, logic ovchk);
        dec_t d;
        d = '0;
        case (fn)
            AF_ADD:  d.aluctrl.f_add  = 1'b1;
            AF_SL:   d.aluctrl.f_sl   = 1'b1;
            AF_SR:   d.aluctrl.f_sr   = 1'b1;
            AF_AND:  d.aluctrl.f_and  = 1'b1;
            AF_OR:   d.aluctrl.f_or   = 1'b1;
            AF_XOR:  d.aluctrl.f_xor  = 1'b1;
            AF_SLT:  d.aluctrl.f_slt  = 1'b1;
            AF_SLTU: d.aluctrl.f_sltu = 1'b1;
            AF_MOVA: d.aluctrl.f_mova = 1'b1;
            default: d.aluctrl.f_add  = 1'b0;
        endcase
        d.aluctrl.alt = alt;
        d.asel        = asel;
        d.bsel        = bsel;
        d.ovchk       = ovchk;
        d.alu         = 1'b1;
        return d;
    endfunction

    function automatic dec_t ri_op();
        dec_t d;
        d    = '0;
        d.ri = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode_comb.sv
// Combinational MIPS32 ALU-class decoder: instruction word -> aluctrl/asel/bsel/ovchk/alu/ri.
// MOVZ/MOVN decode as ALU ops only when ALU_DECODE_MOVCOND_EN is defined, otherwise as reserved.
module alu_ctrl_decode_comb
    import alu_ctrl_decode_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused_fields;

    assign w_opcode        = i_instr[31:26];
    assign w_funct         = i_instr[5:0];
    assign w_unused_fields = ^i_instr[25:6];

    always_comb begin
        // NOTE: default every output first so no path through the cases can infer a latch.
        o_dec = '0;
        if (w_opcode == OP_SPECIAL) begin
            case (w_funct)
                FN_SLL:  o_dec = alu_op(AF_SL,   1'b0, ASEL_SHAMT, BSEL_RT, 1'b0);
                FN_SRL:  o_dec = alu_op(AF_SR,   1'b0, ASEL_SHAMT, BSEL_RT, 1'b0);
                FN_SRA:  o_dec = alu_op(AF_SR,   1'b1, ASEL_SHAMT, BSEL_RT, 1'b0);
                FN_SLLV: o_dec = alu_op(AF_SL,   1'b0, ASEL_RS,    BSEL_RT, 1'b0);
                FN_SRLV: o_dec = alu_op(AF_SR,   1'b0, ASEL_RS,    BSEL_RT, 1'b0);
                FN_SRAV: o_dec = alu_op(AF_SR,   1'b1, ASEL_RS,    BSEL_RT, 1'b0);
                FN_ADD:  o_dec = alu_op(AF_ADD,  1'b0, ASEL_RS,    BSEL_RT, 1'b1);
                FN_ADDU: o_dec = alu_op(AF_ADD,  1'b0, ASEL_RS,    BSEL_RT, 1'b0);
                FN_SUB:  o_dec = alu_op(AF_ADD,  1'b1, ASEL_RS,    BSEL_RT, 1'b1);
                FN_SUBU: o_dec = alu_op(AF_ADD,  1'b1, ASEL_RS,    BSEL_RT, 1'b0);
                FN_AND:  o_dec = alu_op(AF_AND,  1'b0, ASEL_RS,    BSEL_RT, 1'b0);
                FN_OR:   o_dec = alu_op(AF_OR,   1'b0, ASEL_RS,    BSEL_RT, 1'b0);
                FN_XOR:  o_dec = alu_op(AF_XOR,  1'b0, ASEL_RS,    BSEL_RT, 1'b0);
                FN_NOR:  o_dec = alu_op(AF_OR,   1'b1, ASEL_RS,    BSEL_RT, 1'b0);
                FN_SLT:  o_dec = alu_op(AF_SLT,  1'b1, ASEL_RS,    BSEL_RT, 1'b0);
                FN_SLTU: o_dec = alu_op(AF_SLTU, 1'b1, ASEL_RS,    BSEL_RT, 1'b0);
`ifdef ALU_DECODE_MOVCOND_EN
                // Write-back gating on rt happens in execute; here it is a plain move of rs.
                FN_MOVZ: o_dec = alu_op(AF_MOVA, 1'b0, ASEL_RS,    BSEL_RT, 1'b0);
                FN_MOVN: o_dec = alu_op(AF_MOVA, 1'b0, ASEL_RS,    BSEL_RT, 1'b0);
`endif
                default: o_dec = ri_op();
            endcase
        end else begin
            case (w_opcode)
                OP_ADDI:  o_dec = alu_op(AF_ADD,  1'b0, ASEL_RS,   BSEL_IMM_SEXT, 1'b1);
                OP_ADDIU: o_dec = alu_op(AF_ADD,  1'b0, ASEL_RS,   BSEL_IMM_SEXT, 1'b0);
                OP_SLTI:  o_dec = alu_op(AF_SLT,  1'b1, ASEL_RS,   BSEL_IMM_SEXT, 1'b0);
                OP_SLTIU: o_dec = alu_op(AF_SLTU, 1'b1, ASEL_RS,   BSEL_IMM_SEXT, 1'b0);
                OP_ANDI:  o_dec = alu_op(AF_AND,  1'b0, ASEL_RS,   BSEL_IMM_ZEXT, 1'b0);
                OP_ORI:   o_dec = alu_op(AF_OR,   1'b0, ASEL_RS,   BSEL_IMM_ZEXT, 1'b0);
                OP_XORI:  o_dec = alu_op(AF_XOR,  1'b0, ASEL_RS,   BSEL_IMM_ZEXT, 1'b0);
                OP_LUI:   o_dec = alu_op(AF_OR,   1'b0, ASEL_ZERO, BSEL_IMM_LUI,  1'b0);
                default:  o_dec = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_decode.sv
// Registered ALU control decode stage with valid/ready handshake and a one-entry skid buffer.
// Optional MOVZ/MOVN support is enabled by defining ALU_DECODE_MOVCOND_EN.
module alu_ctrl_decode
    import alu_ctrl_decode_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output aluctrl_t        out_aluctrl,
    output asel_t           out_asel,
    output bsel_t           out_bsel,
    output logic            out_ovchk,
    output logic            out_alu,
    output logic            out_ri
);

    dec_t            w_dec;
    logic            w_accept;
    logic            w_out_load;

    logic            r_out_valid;
    logic [PC_W-1:0] r_out_pc;
    dec_t            r_out_dec;
    logic            r_skid_valid;
    logic [PC_W-1:0] r_skid_pc;
    dec_t            r_skid_dec;

    alu_ctrl_decode_comb u_comb (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    // The skid entry only fills while the output is held, so its occupancy alone gates input.
    assign in_ready   = ~r_skid_valid;
    assign w_accept   = in_valid & in_ready;
    assign w_out_load = ~r_out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_load) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid  <= w_accept;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: payload registers are reset too, so the outputs read as all-zero straight out of reset.
        if (rst) begin
            r_out_pc   <= '0;
            r_out_dec  <= '0;
            r_skid_pc  <= '0;
            r_skid_dec <= '0;
        end else if (!flush) begin
            if (w_out_load) begin
                if (r_skid_valid) begin
                    r_out_pc  <= r_skid_pc;
                    r_out_dec <= r_skid_dec;
                end else if (w_accept) begin
                    r_out_pc  <= in_pc;
                    r_out_dec <= w_dec;
                end
            end else if (w_accept) begin
                r_skid_pc  <= in_pc;
                r_skid_dec <= w_dec;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = r_out_pc;
    assign out_aluctrl = r_out_dec.aluctrl;
    assign out_asel    = r_out_dec.asel;
    assign out_bsel    = r_out_dec.bsel;
    assign out_ovchk   = r_out_dec.ovchk;
    assign out_alu     = r_out_dec.alu;
    assign out_ri      = r_out_dec.ri;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Self-checking bench for alu_ctrl_decode: directed decode, backpressure, flush, reset and a random stream.
// Expectations for MOVZ/MOVN follow ALU_DECODE_MOVCOND_EN.
module tb_alu_ctrl_decode;
    import alu_ctrl_decode_pkg::*;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    aluctrl_t        out_aluctrl;
    asel_t           out_asel;
    bsel_t           out_bsel;
    logic            out_ovchk;
    logic            out_alu;
    logic            out_ri;

    alu_ctrl_decode #(.PC_W(PC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_aluctrl (out_aluctrl),
        .out_asel    (out_asel),
        .out_bsel    (out_bsel),
        .out_ovchk   (out_ovchk),
        .out_alu     (out_alu),
        .out_ri      (out_ri)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        aluctrl_t   ctl;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic       ovchk;
        logic       alu;
        logic       ri;
    } exp_t;

    typedef struct {
        bit        is_special;
        bit [5:0]  code;
        string     fn;
        bit        alt;
        int        asel;
        int        bsel;
        bit        ovchk;
    } rule_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } beat_t;

    rule_t rules[$];

    function automatic aluctrl_t ctl_of(string fn, bit alt);
        aluctrl_t c;
        c = '0;
        if (fn == "add")  c.f_add  = 1'b1;
        if (fn == "sl")   c.f_sl   = 1'b1;
        if (fn == "sr")   c.f_sr   = 1'b1;
        if (fn == "and")  c.f_and  = 1'b1;
        if (fn == "or")   c.f_or   = 1'b1;
        if (fn == "xor")  c.f_xor  = 1'b1;
        if (fn == "slt")  c.f_slt  = 1'b1;
        if (fn == "sltu") c.f_sltu = 1'b1;
        if (fn == "mova") c.f_mova = 1'b1;
        c.alt = alt;
        return c;
    endfunction

    function automatic exp_t mk_exp(string fn, bit alt, int asel, int bsel, bit ov, bit alu, bit ri);
        exp_t e;
        e.ctl   = ctl_of(fn, alt);
        e.asel  = 2'(asel);
        e.bsel  = 2'(bsel);
        e.ovchk = ov;
        e.alu   = alu;
        e.ri    = ri;
        return e;
    endfunction

    function automatic void add_rule(bit sp, bit [5:0] code, string fn, bit alt, int asel, int bsel, bit ov);
        rule_t r;
        r.is_special = sp; r.code = code; r.fn = fn; r.alt = alt;
        r.asel = asel; r.bsel = bsel; r.ovchk = ov;
        rules.push_back(r);
    endfunction

    // Decode rules as a flat table: (special?, code, function, alt, asel, bsel, ovchk).
    function automatic void init_rules();
        add_rule(1, 6'h00, "sl",   0, 1, 0, 0);
        add_rule(1, 6'h02, "sr",   0, 1, 0, 0);
        add_rule(1, 6'h03, "sr",   1, 1, 0, 0);
        add_rule(1, 6'h04, "sl",   0, 0, 0, 0);
        add_rule(1, 6'h06, "sr",   0, 0, 0, 0);
        add_rule(1, 6'h07, "sr",   1, 0, 0, 0);
        add_rule(1, 6'h20, "add",  0, 0, 0, 1);
        add_rule(1, 6'h21, "add",  0, 0, 0, 0);
        add_rule(1, 6'h22, "add",  1, 0, 0, 1);
        add_rule(1, 6'h23, "add",  1, 0, 0, 0);
        add_rule(1, 6'h24, "and",  0, 0, 0, 0);
        add_rule(1, 6'h25, "or",   0, 0, 0, 0);
        add_rule(1, 6'h26, "xor",  0, 0, 0, 0);
        add_rule(1, 6'h27, "or",   1, 0, 0, 0);
        add_rule(1, 6'h2A, "slt",  1, 0, 0, 0);
        add_rule(1, 6'h2B, "sltu", 1, 0, 0, 0);
`ifdef ALU_DECODE_MOVCOND_EN
        add_rule(1, 6'h0A, "mova", 0, 0, 0, 0);
        add_rule(1, 6'h0B, "mova", 0, 0, 0, 0);
`endif
        add_rule(0, 6'h08, "add",  0, 0, 1, 1);
        add_rule(0, 6'h09, "add",  0, 0, 1, 0);
        add_rule(0, 6'h0A, "slt",  1, 0, 1, 0);
        add_rule(0, 6'h0B, "sltu", 1, 0, 1, 0);
        add_rule(0, 6'h0C, "and",  0, 0, 2, 0);
        add_rule(0, 6'h0D, "or",   0, 0, 2, 0);
        add_rule(0, 6'h0E, "xor",  0, 0, 2, 0);
        add_rule(0, 6'h0F, "or",   0, 2, 3, 0);
    endfunction

    function automatic exp_t model(logic [31:0] instr);
        exp_t     e;
        bit [5:0] op;
        bit [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        e  = '0;
        foreach (rules[i]) begin
            if ((rules[i].is_special && op == 6'h00 && rules[i].code == fn) ||
                (!rules[i].is_special && op != 6'h00 && rules[i].code == op)) begin
                return mk_exp(rules[i].fn, rules[i].alt, rules[i].asel, rules[i].bsel, rules[i].ovchk, 1'b1, 1'b0);
            end
        end
        if (op == 6'h00) e.ri = 1'b1;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.ctl   = out_aluctrl;
        o.asel  = out_asel;
        o.bsel  = out_bsel;
        o.ovchk = out_ovchk;
        o.alu   = out_alu;
        o.ri    = out_ri;
        return o;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k < 5)      r[31:26] = 6'h00;
        else if (k < 8) r[31:26] = 6'($urandom_range(8, 15));
        return r;
    endfunction

    // Empties the stage through a flush cycle; leaves inputs idle at a falling edge.
    task automatic settle();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
    endtask

    task automatic send_one(logic [31:0] instr, logic [31:0] pc);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #12;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        n_tests++;
        if (observe() !== '0 || out_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: dec=%h pc=%h want 0/0", observe(), out_pc);
        end
        rst = 1'b0;
        // Reset asserted while both entries hold beats
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00221820; in_pc = 32'h40;
        @(negedge clk);
        in_pc = 32'h44;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_partial: out_valid=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_decode_directed();
        logic [31:0] instrs[7];
        exp_t        exps[7];
        instrs[0] = 32'h00221820; exps[0] = mk_exp("add", 0, 0, 0, 1, 1, 0);
        instrs[1] = 32'h00021903; exps[1] = mk_exp("sr",  1, 1, 0, 0, 1, 0);
        instrs[2] = 32'h00221823; exps[2] = mk_exp("add", 1, 0, 0, 0, 1, 0);
        instrs[3] = 32'h3C011234; exps[3] = mk_exp("or",  0, 2, 3, 0, 1, 0);
        instrs[4] = 32'h0000003F; exps[4] = mk_exp("",    0, 0, 0, 0, 0, 1);
        instrs[5] = 32'h8C220000; exps[5] = mk_exp("",    0, 0, 0, 0, 0, 0);
`ifdef ALU_DECODE_MOVCOND_EN
        instrs[6] = 32'h0022180A; exps[6] = mk_exp("mova", 0, 0, 0, 0, 1, 0);
`else
        instrs[6] = 32'h0022180A; exps[6] = mk_exp("",    0, 0, 0, 0, 0, 1);
`endif
        settle();
        for (int i = 0; i < 7; i++) begin
            send_one(instrs[i], 32'h1000 + 32'(i * 4));
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'h1000 + 32'(i * 4)) begin
                n_fail++;
                $display("FAIL dir_latency[%0d]: valid=%b pc=%h want 1/%h", i, out_valid, out_pc, 32'h1000 + 32'(i * 4));
            end
            n_tests++;
            if (observe() !== exps[i]) begin
                n_fail++;
                $display("FAIL dir_decode[%0d] instr=%h: got=%h want=%h", i, instrs[i], observe(), exps[i]);
            end
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_no_dup: out_valid=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] pcs[3];
        int          idx;
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        idx = 0;
        settle();
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_instr = 32'h00221820; in_pc = pcs[idx]; out_ready = 1'b0;
            if (in_ready === 1'b1) idx++;
            @(negedge clk);
        end
        n_tests++;
        if (idx != 2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: accepted=%0d in_ready=%b want 2/0", idx, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_pc = pcs[idx];
            in_valid = (idx < 3);
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== pcs[c]) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: valid=%b pc=%h want 1/%h", c, out_valid, out_pc, pcs[c]);
            end
            if (in_valid && in_ready === 1'b1) idx++;
            @(negedge clk);
            in_valid = 1'b0;
        end
        n_tests++;
        if (out_valid !== 1'b0 || idx != 3) begin
            n_fail++;
            $display("FAIL bp_drain: valid=%b accepted=%0d want 0/3", out_valid, idx);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        settle();
        in_valid = 1'b1; in_instr = 32'h00221825; in_pc = 32'h200; out_ready = 1'b0;
        @(negedge clk);
        in_pc = 32'h204;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        end
        flush = 1'b1; in_pc = 32'h208; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_leak[%0d]: out_valid=%b pc=%h want 0", c, out_valid, out_pc);
            end
        end
        send_one(32'h00221824, 32'h20C);
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h20C) begin
            n_fail++;
            $display("FAIL flush_resume: valid=%b pc=%h want 1/20c", out_valid, out_pc);
        end
        out_ready = 1'b0;
    endtask

    // Random valid/ready/flush traffic against a queue of in-flight beats (capacity two).
    task automatic test_random_stream();
        beat_t q[$];
        beat_t b;
        logic  exp_out_valid;
        logic  exp_in_ready;
        logic  out_fire;
        logic  in_fire;
        settle();
        for (int c = 0; c < 3000; c++) begin
            exp_out_valid = (q.size() > 0);
            exp_in_ready  = (q.size() < 2);
            n_tests++;
            if (out_valid !== exp_out_valid || in_ready !== exp_in_ready) begin
                n_fail++;
                $display("FAIL rnd_hs[%0d]: out_valid=%b in_ready=%b want %b/%b", c, out_valid, in_ready, exp_out_valid, exp_in_ready);
            end
            if (exp_out_valid) begin
                n_tests++;
                if (out_pc !== q[0].pc || observe() !== model(q[0].instr)) begin
                    n_fail++;
                    $display("FAIL rnd_beat[%0d]: pc=%h dec=%h want pc=%h dec=%h", c, out_pc, observe(), q[0].pc, model(q[0].instr));
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            out_fire  = exp_out_valid && out_ready;
            in_fire   = in_valid && exp_in_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (out_fire) void'(q.pop_front());
                if (in_fire) begin
                    b.instr = in_instr;
                    b.pc    = in_pc;
                    q.push_back(b);
                end
            end
            @(negedge clk);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        init_rules();
        test_reset();
        test_decode_directed();
        test_backpressure();
        test_flush();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_decode.md
Name: alu_ctrl_decode

Overview:
- Instruction-side producer of the `aluctrl_t` control word consumed by the core's ALU.
- Takes fetched MIPS32 instruction words and decodes the ALU-class subset into four outputs: `aluctrl_t`, operand-A select, operand-B select and an overflow-trap enable.
- One registered pipeline stage with valid/ready handshake and a one-entry skid buffer, placed between fetch and execute.

Parameters:
- PC_W, 32, width of the PC carried alongside each instruction.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  squash all held and incoming instructions
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat (registered)
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  decoded beat valid
- out_ready  in  1  execute stage accepts beat
- out_pc  out  PC_W  PC of decoded beat
- out_aluctrl  out  aluctrl_t  ALU function one-hot plus alt bit
- out_asel  out  2  operand A select: 0=RS, 1=SHAMT, 2=ZERO
- out_bsel  out  2  operand B select: 0=RT, 1=IMM_SEXT, 2=IMM_ZEXT, 3=IMM_LUI (imm<<16)
- out_ovchk  out  1  raise integer-overflow exception on ALU overflow
- out_alu  out  1  instruction is ALU-class (all other outputs valid only then)
- out_ri  out  1  reserved instruction (SPECIAL with unknown funct)

Behaviour:
- Reset (async, rst=1): out_valid=0, in_ready=1, skid empty, all payload outputs 0.
- Decode table, SPECIAL (opcode 0), by funct:
  - SLL 00 / SRL 02 / SRA 03: f_sl / f_sr / f_sr+alt; asel=SHAMT, bsel=RT.
  - SLLV 04 / SRLV 06 / SRAV 07: same functions; asel=RS, bsel=RT.
  - ADD 20 / ADDU 21: f_add, alt=0; ovchk=1 only for ADD.
  - SUB 22 / SUBU 23: f_add, alt=1; ovchk=1 only for SUB.
  - AND 24: f_and. OR 25: f_or. XOR 26: f_xor. NOR 27: f_or+alt.
  - SLT 2A / SLTU 2B: f_slt / f_sltu, alt=1.
  - All SPECIAL entries above use asel=RS, bsel=RT unless stated otherwise.
- Decode table, I-type, by opcode:
  - ADDI 08: f_add, bsel=IMM_SEXT, ovchk=1.
  - ADDIU 09: f_add, bsel=IMM_SEXT.
  - SLTI 0A / SLTIU 0B: f_slt / f_sltu, alt=1, bsel=IMM_SEXT.
  - ANDI 0C / ORI 0D / XORI 0E: f_and / f_or / f_xor, bsel=IMM_ZEXT.
  - LUI 0F: f_or, asel=ZERO, bsel=IMM_LUI.
  - All I-type entries use asel=RS unless stated otherwise.
- Exactly one `f_*` bit is set when out_alu=1. All outputs are zero when out_alu=0.
- SPECIAL with a funct not in the table: out_alu=0, out_ri=1. Any other opcode: out_alu=0, out_ri=0 (owned by other decoders).
- Latency: 1 cycle from accepted input to out_valid.
- Handshake: a beat transfers when valid&&ready. The output register loads when it is empty or out_ready=1.
- Skid buffer: if out_valid=1, out_ready=0 and a beat is accepted, that beat goes to the skid entry and in_ready drops the next cycle. When the output drains, the skid entry moves to the output and in_ready returns to 1 the next cycle.
- Order is strictly preserved. No beat is lost or duplicated under any out_ready pattern.
- Flush: next cycle out_valid=0, skid empty, in_ready=1. An input beat presented in the flush cycle is dropped. Flush dominates simultaneous handshakes.
- rst asserted mid-transfer: state clears immediately; no partial beat is emitted.

Optional Feature:
- Macro: ALU_DECODE_MOVCOND_EN.
- With the macro defined: MOVZ (funct 0A) and MOVN (funct 0B) decode to f_mova, asel=RS, bsel=RT, out_alu=1. The execute stage gates the write-back on rt.
- Without the macro: MOVZ/MOVN decode as out_ri=1, out_alu=0.

Decomposition:
- Shared package: `aluctrl_t` (already in the shared defines), new enums `asel_t` and `bsel_t`, and opcode/funct localparams.
- Sub-module `alu_ctrl_decode_comb`: purely combinational instr -> {aluctrl, asel, bsel, ovchk, alu, ri}.
- Top level holds the output register, skid register and handshake.

Test Plan:
- 0x00221820 (ADD $3,$1,$2) -> one cycle later out_valid=1, f_add=1, alt=0, asel=RS, bsel=RT, ovchk=1.
- 0x00021903 (SRA $3,$2,4) -> f_sr=1, alt=1, asel=SHAMT, bsel=RT, ovchk=0; 0x00221823 (SUBU) -> f_add=1, alt=1, ovchk=0.
- 0x3C011234 (LUI) -> f_or=1, asel=ZERO, bsel=IMM_LUI; 0x0000003F -> out_ri=1, out_alu=0; 0x8C220000 (LW) -> out_alu=0, out_ri=0.
- Backpressure:
  - Stimulus: in_valid=1 with PCs 0x100, 0x104, 0x108; out_ready=0 for 3 cycles.
  - Required: exactly two beats accepted and in_ready=0.
  - Then out_ready=1: outputs emerge in order 0x100, 0x104, 0x108 with no gaps.
- Flush with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed PCs never appear at the output.
- 0x0022180A (MOVZ) with ALU_DECODE_MOVCOND_EN -> f_mova=1, out_alu=1; without the macro -> out_ri=1.
